count_monitor: RTL and testbench
================================

COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16: width of the observed count bus and the compare register.
REQ-002 SHALL have parameter EVT_WIDTH, default 8: width of the saturating event counter.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port count  input  COUNT_WIDTH  live value from the upstream counter, synchronous to clk.
REQ-006 SHALL have port cmp_val  input  COUNT_WIDTH  compare value to be written.
REQ-007 SHALL have port cmp_wr  input  1  write strobe; loads cmp_val into the compare register.
REQ-008 SHALL have port irq_ack  input  1  interrupt acknowledge, level, from the consumer.
REQ-009 SHALL have port irq  output  1  interrupt request, level.
REQ-010 SHALL have port match_pulse  output  1  one-cycle compare-match event.
REQ-011 SHALL have port wrap_pulse  output  1  one-cycle wrap event (all-ones to zero).
REQ-012 SHALL have port status  output  3  sticky flags: [0] match, [1] wrap, [2] overflow.
REQ-013 SHALL have port event_cnt  output  EVT_WIDTH  saturating total of detected events.

Function
REQ-014 SHALL register count into count_q every cycle and set a prime flag one cycle after reset release; no event SHALL be detected while prime = 0.
REQ-015 SHALL detect a match in a cycle where prime = 1, count == cmp_reg and count != count_q, so a stalled counter does not re-trigger.
REQ-016 SHALL detect a wrap in a cycle where prime = 1, count_q == all-ones and count == 0; a return to 0 from any other value SHALL NOT be a wrap.
REQ-017 SHALL assert match_pulse and wrap_pulse for exactly one cycle, starting at the rising edge after detection (latency 1); both MAY assert together.
REQ-018 SHALL update cmp_reg on the edge where cmp_wr = 1; detection in the write cycle SHALL use the old cmp_reg.
REQ-019 SHALL set status[0] and status[1] on their detection edge; these bits SHALL remain set until cleared per REQ-022.
REQ-020 SHALL increment event_cnt by the number of events detected in a cycle (0, 1 or 2), saturating at all-ones with no wrap.
REQ-021 SHALL implement IRQ FSM IDLE -> PEND when any status bit is set; in PEND, irq = 1; PEND -> ACKD on irq_ack = 1; ACKD -> IDLE on irq_ack = 0; irq = 0 in IDLE and ACKD.
REQ-022 SHALL clear all status bits on the PEND -> ACKD edge, except bits whose event is detected in that same cycle, which SHALL remain set.
REQ-023 SHALL NOT leave ACKD while irq_ack stays high; events in ACKD SHALL set status, and FSM SHALL re-enter PEND via IDLE after irq_ack falls.
REQ-024 SHALL ignore irq_ack while in IDLE.

Reset
REQ-025 SHALL, while reset = 0, force irq = 0, match_pulse = 0, wrap_pulse = 0, status = 0, event_cnt = 0, cmp_reg = 0, count_q = 0, prime = 0, FSM = IDLE.
REQ-026 SHALL discard any event and any pending IRQ on reset assertion mid-operation; count_q SHALL re-prime per REQ-014 after release.

Configuration
REQ-027 SHALL, with macro COUNT_MONITOR_OVF_EN defined, set status[2] when an event is detected while its status bit is already set; status[2] SHALL be cleared per REQ-022 and SHALL count as a status bit for REQ-021.
REQ-028 SHALL, without COUNT_MONITOR_OVF_EN, tie status[2] to 0, and SHALL contain no overflow logic.

Verification
REQ-029 Match: cmp_wr with cmp_val = 0x0005, count ramps 0x0003..0x0008 -> match_pulse high exactly one cycle after count = 0x0005; status = 3'b001; irq = 1; event_cnt = 1.
REQ-030 Stall: cmp_reg = 0x0005, count held at 0x0005 for 10 cycles -> exactly one match_pulse; event_cnt = 1.
REQ-031 Wrap: count 0xFFFE, 0xFFFF, 0x0000 -> wrap_pulse one cycle after 0x0000; status[1] = 1; forcing count 0x1234 -> 0x0000 gives no wrap_pulse.
REQ-032 Handshake: irq = 1, raise irq_ack for 3 cycles with a match in the ack-edge cycle -> irq drops; status[0] stays 1; irq returns 1 two cycles after irq_ack falls (ACKD -> IDLE -> PEND).
REQ-033 Saturation/overflow: 300 matches with no ack -> event_cnt = 0xFF; with COUNT_MONITOR_OVF_EN status = 3'b101, without it status = 3'b001.
REQ-034 Reset mid-operation: reset = 0 while irq = 1 and event_cnt = 7 -> all outputs 0 immediately; a count equal to cmp_reg in the first cycle after release -> no match_pulse.

Source files
------------

// File: rtl/count_monitor.sv
// Watches a free-running counter for compare matches and all-ones->zero wraps,
// raising sticky status, a saturating event total and a level IRQ. Optional macro: COUNT_MONITOR_OVF_EN.
module count_monitor #(
    parameter int COUNT_WIDTH = 16,
    parameter int EVT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic [COUNT_WIDTH-1:0] cmp_val,
    input  logic                   cmp_wr,
    input  logic                   irq_ack,
    output logic                   irq,
    output logic                   match_pulse,
    output logic                   wrap_pulse,
    output logic [2:0]             status,
    output logic [EVT_WIDTH-1:0]   event_cnt,
    output logic [1:0]             irq_state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACKD = 2'd2
    } irq_state_e;

    irq_state_e             state_q;
    logic                   irq_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] cmp_reg_q;
    logic [COUNT_WIDTH-1:0] cmp_reg_d;
    logic                   prime_q;
    logic                   match_pulse_q;
    logic                   wrap_pulse_q;
    logic [2:0]             status_q;
    logic [2:0]             status_d;
    logic [EVT_WIDTH-1:0]   evt_q;
    logic [EVT_WIDTH-1:0]   evt_d;
    logic [EVT_WIDTH:0]     evt_sum;
    logic [EVT_WIDTH:0]     evt_inc;
    logic                   match_det;
    logic                   wrap_det;
    logic                   ack_edge;

    // A counter that stalls on the compare value must not re-trigger, hence count != count_q.
    assign match_det = prime_q && (count == cmp_reg_q) && (count != count_q);
    assign wrap_det  = prime_q && (count_q == {COUNT_WIDTH{1'b1}}) && (count == '0);
    assign ack_edge  = (state_q == PEND) && irq_ack;

    assign cmp_reg_d = cmp_wr ? cmp_val : cmp_reg_q;

    always_comb begin
        status_d = status_q;
        if (ack_edge) begin
            status_d = '0;
        end
        if (match_det) begin
            status_d[0] = 1'b1;
        end
        if (wrap_det) begin
            status_d[1] = 1'b1;
        end
`ifdef COUNT_MONITOR_OVF_EN
        // Overflow: an event arrived while its own sticky bit was still unserviced.
        if ((match_det && status_q[0]) || (wrap_det && status_q[1])) begin
            status_d[2] = 1'b1;
        end
`else
        status_d[2] = 1'b0;
`endif
    end

    always_comb begin
        evt_inc      = '0;
        evt_inc[1:0] = {match_det & wrap_det, match_det ^ wrap_det};
        evt_sum      = {1'b0, evt_q} + evt_inc;
        evt_d        = evt_sum[EVT_WIDTH] ? {EVT_WIDTH{1'b1}} : evt_sum[EVT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q       <= '0;
            prime_q       <= 1'b0;
            cmp_reg_q     <= '0;
            match_pulse_q <= 1'b0;
            wrap_pulse_q  <= 1'b0;
            status_q      <= '0;
            evt_q         <= '0;
        end else begin
            count_q       <= count;
            prime_q       <= 1'b1;
            cmp_reg_q     <= cmp_reg_d;
            match_pulse_q <= match_det;
            wrap_pulse_q  <= wrap_det;
            status_q      <= status_d;
            evt_q         <= evt_d;
        end
    end

    // IRQ handshake: irq is a level request held in PEND; the consumer answers
    // with a level irq_ack, and a new request is only issued after the ack drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|status_q) begin
                        state_q <= PEND;
                        irq_q   <= 1'b1;
                    end
                end
                PEND: begin
                    if (irq_ack) begin
                        state_q <= ACKD;
                        irq_q   <= 1'b0;
                    end
                end
                ACKD: begin
                    if (!irq_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq           = irq_q;
    assign match_pulse   = match_pulse_q;
    assign wrap_pulse    = wrap_pulse_q;
    assign status        = status_q;
    assign event_cnt     = evt_q;
    assign irq_state_dbg = state_q;

endmodule

// File: tb/tb_count_monitor.sv
// Randomized plus directed bench for count_monitor against a cycle-level
// reference model written directly from the event/status/IRQ rules.
module tb_count_monitor;

    localparam int CW = 16;
    localparam int EW = 8;
    localparam int XW = 1 + 1 + 1 + 3 + EW;

    logic          clk;
    logic          reset;
    logic [CW-1:0] count;
    logic [CW-1:0] cmp_val;
    logic          cmp_wr;
    logic          irq_ack;
    logic          irq;
    logic          match_pulse;
    logic          wrap_pulse;
    logic [2:0]    status;
    logic [EW-1:0] event_cnt;
    logic [1:0]    irq_state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [XW-1:0] exp_q[$];

    count_monitor #(.COUNT_WIDTH(CW), .EVT_WIDTH(EW)) dut (
        .clk           (clk),
        .reset         (reset),
        .count         (count),
        .cmp_val       (cmp_val),
        .cmp_wr        (cmp_wr),
        .irq_ack       (irq_ack),
        .irq           (irq),
        .match_pulse   (match_pulse),
        .wrap_pulse    (wrap_pulse),
        .status        (status),
        .event_cnt     (event_cnt),
        .irq_state_dbg (irq_state_dbg)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int unsigned m_prev;
    int unsigned m_cmp;
    int unsigned m_evt;
    bit          m_primed;
    bit [2:0]    m_flags;
    int          m_phase;   // 0 = no request, 1 = request raised, 2 = acknowledged
    bit          m_irq;
    bit          m_mp;
    bit          m_wp;

    task automatic model_reset();
        m_prev = 0; m_cmp = 0; m_evt = 0; m_primed = 0;
        m_flags = 3'b000; m_phase = 0; m_irq = 0; m_mp = 0; m_wp = 0;
    endtask

    task automatic model_step(input bit r, input int unsigned c, input int unsigned v,
                              input bit w, input bit a);
        bit       hit;
        bit       wr;
        bit [2:0] nf;
        int       nphase;
        if (!r) begin
            model_reset();
            return;
        end
        hit = m_primed && (c == m_cmp) && (c != m_prev);
        wr  = m_primed && (m_prev == 32'hFFFF) && (c == 0);
        nf  = (m_phase == 1 && a) ? 3'b000 : m_flags;
`ifdef COUNT_MONITOR_OVF_EN
        if ((hit && m_flags[0]) || (wr && m_flags[1])) nf[2] = 1'b1;
`endif
        if (hit) nf[0] = 1'b1;
        if (wr)  nf[1] = 1'b1;
        m_evt = m_evt + hit + wr;
        if (m_evt > 255) m_evt = 255;
        nphase = m_phase;
        if (m_phase == 0 && m_flags != 0) nphase = 1;
        else if (m_phase == 1 && a) nphase = 2;
        else if (m_phase == 2 && !a) nphase = 0;
        m_phase  = nphase;
        m_irq    = (nphase == 1);
        m_mp     = hit;
        m_wp     = wr;
        m_flags  = nf;
        m_prev   = c;
        m_primed = 1;
        if (w) m_cmp = v;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [XW-1:0] e;
        if (exp_q.size() == 0) begin
            check_eq("exp_q_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_eq("irq",         {31'd0, irq},         {31'd0, e[XW-1]});
        check_eq("match_pulse", {31'd0, match_pulse}, {31'd0, e[XW-2]});
        check_eq("wrap_pulse",  {31'd0, wrap_pulse},  {31'd0, e[XW-3]});
        check_eq("status",      {29'd0, status},      {29'd0, e[EW+2:EW]});
        check_eq("event_cnt",   {24'd0, event_cnt},   {24'd0, e[EW-1:0]});
    endtask

    // Driver: apply one cycle of inputs at the falling edge, check after the rising edge
    task automatic step(input bit r, input logic [CW-1:0] c, input logic [CW-1:0] v,
                        input bit w, input bit a);
        @(negedge clk);
        reset = r; count = c; cmp_val = v; cmp_wr = w; irq_ack = a;
        model_step(r, c, v, w, a);
        exp_q.push_back({m_irq, m_mp, m_wp, m_flags, m_evt[EW-1:0]});
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        step(0, 16'h0, 16'h0, 0, 0);
        step(0, 16'h0, 16'h0, 0, 0);
    endtask

    logic [CW-1:0] cur_c;
    bit            cur_a;

    initial begin
        reset = 1'b0; count = '0; cmp_val = '0; cmp_wr = 1'b0; irq_ack = 1'b0;
        model_reset();
        do_reset();
        check_eq("reset_status", {29'd0, status}, 32'd0);
        check_eq("reset_evt", {24'd0, event_cnt}, 32'd0);

        // Compare match on a ramp
        step(1, 16'h0003, 16'h0005, 1, 0);
        for (int i = 4; i <= 8; i++) step(1, 16'(i), 16'h0, 0, 0);
        check_eq("ramp_status", {29'd0, status}, 32'd1);
        check_eq("ramp_irq", {31'd0, irq}, 32'd1);
        check_eq("ramp_evt", {24'd0, event_cnt}, 32'd1);

        // Stalled counter sitting on the compare value
        do_reset();
        step(1, 16'h0004, 16'h0005, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 16'h0005, 16'h0, 0, 0);
        check_eq("stall_evt", {24'd0, event_cnt}, 32'd1);

        // Wrap and non-wrap return to zero
        do_reset();
        step(1, 16'hFFF0, 16'h4321, 1, 0);
        step(1, 16'hFFFE, 16'h0, 0, 0);
        step(1, 16'hFFFF, 16'h0, 0, 0);
        step(1, 16'h0000, 16'h0, 0, 0);
        check_eq("wrap_status1", {31'd0, status[1]}, 32'd1);
        step(1, 16'h1234, 16'h0, 0, 0);
        step(1, 16'h0000, 16'h0, 0, 0);
        check_eq("no_wrap_from_1234", {31'd0, wrap_pulse}, 32'd0);

        // Handshake with a match landing on the acknowledge edge
        do_reset();
        step(1, 16'h0006, 16'h0007, 1, 0);
        step(1, 16'h0007, 16'h0, 0, 0);
        step(1, 16'h0008, 16'h0, 0, 0);
        step(1, 16'h0008, 16'h0, 0, 0);
        check_eq("hs_irq_before", {31'd0, irq}, 32'd1);
        step(1, 16'h0007, 16'h0, 0, 1);
        check_eq("hs_irq_dropped", {31'd0, irq}, 32'd0);
        check_eq("hs_status0_kept", {31'd0, status[0]}, 32'd1);
        step(1, 16'h0007, 16'h0, 0, 1);
        step(1, 16'h0007, 16'h0, 0, 1);
        step(1, 16'h0007, 16'h0, 0, 0);
        check_eq("hs_irq_idle", {31'd0, irq}, 32'd0);
        step(1, 16'h0007, 16'h0, 0, 0);
        check_eq("hs_irq_repend", {31'd0, irq}, 32'd1);

        // Saturation of the event total
        do_reset();
        step(1, 16'h0006, 16'h0005, 1, 0);
        for (int i = 0; i < 300; i++) begin
            step(1, 16'h0005, 16'h0, 0, 0);
            step(1, 16'h0006, 16'h0, 0, 0);
        end
        check_eq("sat_evt", {24'd0, event_cnt}, 32'hFF);
`ifdef COUNT_MONITOR_OVF_EN
        check_eq("sat_status", {29'd0, status}, 32'd5);
`else
        check_eq("sat_status", {29'd0, status}, 32'd1);
`endif

        // Reset asserted mid-operation
        do_reset();
        step(1, 16'h0006, 16'h0005, 1, 0);
        for (int i = 0; i < 7; i++) begin
            step(1, 16'h0005, 16'h0, 0, 0);
            step(1, 16'h0006, 16'h0, 0, 0);
        end
        check_eq("pre_rst_evt", {24'd0, event_cnt}, 32'd7);
        check_eq("pre_rst_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("async_rst_irq", {31'd0, irq}, 32'd0);
        check_eq("async_rst_status", {29'd0, status}, 32'd0);
        check_eq("async_rst_evt", {24'd0, event_cnt}, 32'd0);
        check_eq("async_rst_pulses", {30'd0, match_pulse, wrap_pulse}, 32'd0);
        step(0, 16'h0000, 16'h0, 0, 0);
        step(1, 16'h0000, 16'h0, 0, 0);
        step(1, 16'h0000, 16'h0, 0, 0);
        check_eq("post_rst_no_match", {31'd0, match_pulse}, 32'd0);

        // Randomized traffic
        cur_c = 16'h0;
        cur_a = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            case ($urandom_range(0, 5))
                0: cur_c = 16'(m_cmp);
                1: cur_c = 16'hFFFF;
                2: cur_c = 16'h0000;
                3: cur_c = cur_c;
                4: cur_c = cur_c + 16'd1;
                default: cur_c = 16'($urandom_range(0, 65535));
            endcase
            if ($urandom_range(0, 3) == 0) cur_a = ~cur_a;
            step(($urandom_range(0, 299) != 0), cur_c, 16'($urandom_range(0, 7)),
                 ($urandom_range(0, 15) == 0), cur_a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
